// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore control FSM for a multicycle MIPS datapath. Decodes
//                op/funct from the IR and steps each instruction through
//                fetch, decode, execute, memory and writeback states.
//                Also keeps a retired-instruction counter for debug.
//  Ports       : clk, rst (async, active-low)
//                op[5:0], funct[5:0], zero            - decode inputs
//                IorD, MemWrite, IRWrite, RegDst,
//                MemtoReg, RegWrite, ALUSrcA,
//                ALUSrcB[1:0], ALUControl[2:0],
//                PCSrc[1:0], PCEn                      - datapath controls
//                state_out[3:0], instr_done,
//                retired[CNT_W-1:0]                    - debug
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic [3:0]       state_out,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    // ------------------------------------------------------------------
    // State encoding (visible on state_out)
    // ------------------------------------------------------------------
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_EXECUTE = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;
    localparam logic [3:0] S_JUMP    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       state_q, state_d;
    logic             instr_done_q;
    logic [CNT_W-1:0] retired_q;

    logic             pc_write;
    logic             branch;
    logic             retire;
    logic             funct_legal;
    logic [2:0]       funct_alu;

    // R-type funct decode; unknown functs fall back to add and are not
    // allowed to reach writeback.
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = funct_legal ? S_ALUWB : S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        PCSrc      = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = 1'b1;
                pc_write   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                retire   = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
                retire     = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The only non-Moore output: a taken branch loads the PC in BRANCH.
    assign PCEn = pc_write | (branch & zero);

    // ------------------------------------------------------------------
    // Retire tracking: pulse and counter update on the edge leaving the
    // retiring state, so both are visible during the following FETCH.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_done_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            instr_done_q <= retire;
            if (retire) begin
                retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    assign state_out  = state_q;
    assign instr_done = instr_done_q;
    assign retired    = retired_q;

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the register file and drives its write enable (WE3) and write-address select. It also sequences the PC, IR, memory and ALU muxes.
- Decodes op/funct from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback cycles.
- Keeps a retired-instruction counter for debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  6  instruction[31:26] from the IR.
- funct  in  6  instruction[5:0] from the IR.
- zero  in  1  ALU zero flag.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  IR load enable.
- RegDst  out  1  A3 select: 0 = rt, 1 = rd.
- MemtoReg  out  1  WD3 select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file WE3.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC load enable.
- state_out  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
Reset:
- rst low asynchronously forces state IDLE(0), retired = 0, instr_done = 0.
- All control outputs are 0 in IDLE.
- The first rising edge with rst high moves IDLE -> FETCH.
- rst asserted mid-instruction aborts it: no write completes after the reset edge.

Output timing:
- All control outputs except PCEn are decoded from the state register only (Moore).
- PCEn = PCWrite | (Branch & zero), combinational. PCWrite and Branch are internal, state-decoded.

State encoding and actions (unlisted outputs are 0):
- FETCH(1): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=1, PCWrite=1. -> DECODE.
- DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUControl=010. Next state by op:
  - 0x23 / 0x2B -> MEMADR
  - 0x00 -> EXECUTE
  - 0x04 -> BRANCH
  - 0x08 -> ADDIEX
  - 0x02 -> JUMP
  - any other op -> FETCH (illegal opcode: no retire, no write).
- MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUControl=010. op 0x23 -> MEMRD, op 0x2B -> MEMWR.
- MEMRD(4): IorD=1. -> MEMWB.
- MEMWB(5): RegDst=0, MemtoReg=1, RegWrite=1. -> FETCH, retire.
- MEMWR(6): IorD=1, MemWrite=1. -> FETCH, retire.
- EXECUTE(7): ALUSrcA=1, ALUSrcB=00, ALUControl from funct:
  - 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111.
  - Legal funct -> ALUWB.
  - Unknown funct -> ALUControl=010, next state FETCH, no retire.
- ALUWB(8): RegDst=1, MemtoReg=0, RegWrite=1. -> FETCH, retire.
- BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1. -> FETCH, retire (whether or not the branch is taken).
- ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUControl=010. -> ADDIWB.
- ADDIWB(11): RegDst=0, MemtoReg=0, RegWrite=1. -> FETCH, retire.
- JUMP(12): PCSrc=10, PCWrite=1. -> FETCH, retire.
- Encodings 13-15 -> FETCH on the next edge; outputs 0.

Retire:
- Registered: instr_done goes high for exactly the cycle after the retiring state (i.e. during the following FETCH).
- retired increments by 1 on that same edge and wraps modulo 2^CNT_W with no saturation.

Latency per instruction, counted from FETCH to the next FETCH:
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Write constraint:
- RegWrite is high for exactly one cycle per writing instruction, never in FETCH or DECODE.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then release -> state_out = 0 with all outputs 0 during reset; state_out = 1 on the first edge after release; PCEn=1 and IRWrite=1.
- lw, op=0x23: -> states 1,2,3,4,5,1. RegWrite=1 with MemtoReg=1 and RegDst=0 only in state 5. instr_done pulses once; retired = 1.
- R-type, op=0x00, funct=0x2A -> states 1,2,7,8,1. ALUControl=111 in state 7. RegDst=1 and RegWrite=1 in state 8.
- beq, op=0x04:
  - zero=1 -> PCEn=1 in state 9 with PCSrc=01.
  - Repeat with zero=0 -> PCEn=0.
  - Both cases retire; retired increments by 2 in total.
- Illegal cases:
  - op=0x3F -> states 1,2,1 with no RegWrite and retired unchanged.
  - op=0x00, funct=0x3F -> states 1,2,7,1 with no RegWrite.
- Mid-instruction reset: assert rst in state 4 of an lw -> state_out = 0 immediately (asynchronous), RegWrite never asserts, retired = 0; after release the FSM refetches from FETCH.
